// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue/writeback/status bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
);
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic [ADDR_W-1:0]   issue_rs1;
    logic [ADDR_W-1:0]   issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    logic                issue_long;
    logic                issue_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic                flush;
    logic [NUM_REGS-1:0] pending_vec;
    logic [ADDR_W:0]     pending_count;
    logic                timeout_err;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_long,
               wb_valid, wb_rd, flush,
        input  issue_ready, pending_vec, pending_count, timeout_err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_long,
               wb_valid, wb_rd, flush,
        output issue_ready, pending_vec, pending_count, timeout_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-destination tracker with issue stall and watchdog
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int TIMEOUT  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] CNT_ONE = 1;
    localparam logic [WD_W-1:0] WD_ONE  = 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                timeout_q, timeout_d;
    logic                ready, fire, set_en, clr_eff;

    // A same-cycle writeback resolves the hazard through the MEM/WB forward path.
    function automatic logic hit(input logic [ADDR_W-1:0] r,
                                 input logic [NUM_REGS-1:0] pend,
                                 input logic wbv,
                                 input logic [ADDR_W-1:0] wbr);
        return (r != '0) && pend[r] && !(wbv && (wbr == r));
    endfunction

    always_comb begin
        ready = !bus.flush
             && !(bus.issue_use_rs1 && hit(bus.issue_rs1, pending_q, bus.wb_valid, bus.wb_rd))
             && !(bus.issue_use_rs2 && hit(bus.issue_rs2, pending_q, bus.wb_valid, bus.wb_rd))
             && !(bus.issue_long    && hit(bus.issue_rd,  pending_q, bus.wb_valid, bus.wb_rd));
    end

    always_comb begin
        fire      = bus.issue_valid && ready;
        set_en    = fire && bus.issue_long && (bus.issue_rd != '0);
        // A clear only counts when the bit actually drops; set wins on a shared register.
        clr_eff   = bus.wb_valid && (bus.wb_rd != '0) && pending_q[bus.wb_rd]
                 && !(set_en && (bus.issue_rd == bus.wb_rd));
        pending_d = pending_q;
        count_d   = count_q;
        if (bus.flush) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (clr_eff) begin
                pending_d[bus.wb_rd] = 1'b0;
                count_d              = count_d - CNT_ONE;
            end
            if (set_en) begin
                if (!pending_q[bus.issue_rd]) begin
                    count_d = count_d + CNT_ONE;
                end
                pending_d[bus.issue_rd] = 1'b1;
            end
        end

        wd_d = wd_q;
        if (bus.flush || clr_eff || (count_q == '0)) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_ONE;
        end
        timeout_d = timeout_q || (wd_d == WD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.issue_ready   = ready;
    assign bus.pending_vec   = pending_q;
    assign bus.pending_count = count_q;
    assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int TIMEOUT  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) sb_if ();

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb_if.slave)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_rd      = '0;
        sb_if.issue_rs1     = '0;
        sb_if.issue_rs2     = '0;
        sb_if.issue_use_rs1 = 1'b0;
        sb_if.issue_use_rs2 = 1'b0;
        sb_if.issue_long    = 1'b0;
        sb_if.wb_valid      = 1'b0;
        sb_if.wb_rd         = '0;
        sb_if.flush         = 1'b0;
    endtask

    task automatic long_issue(input logic [ADDR_W-1:0] rd);
        idle_inputs();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_long  = 1'b1;
        sb_if.issue_rd    = rd;
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        push("reset_pending_vec", 64'h0);   check(64'(sb_if.pending_vec));
        push("reset_count", 64'h0);         check(64'(sb_if.pending_count));
        push("reset_timeout", 64'h0);       check(64'(sb_if.timeout_err));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Idle consumer of r5
        sb_if.issue_valid = 1'b1; sb_if.issue_rs1 = 5; sb_if.issue_use_rs1 = 1'b1;
        #1;
        push("idle_ready", 64'h1);          check(64'(sb_if.issue_ready));
        push("idle_vec", 64'h0);            check(64'(sb_if.pending_vec));

        // RAW on r7 resolved by same-cycle writeback
        long_issue(7);
        #1;
        push("long7_ready", 64'h1);         check(64'(sb_if.issue_ready));
        step();
        push("long7_vec", 64'h80);          check(64'(sb_if.pending_vec));
        push("long7_count", 64'h1);         check(64'(sb_if.pending_count));
        idle_inputs();
        sb_if.issue_valid = 1'b1; sb_if.issue_rs2 = 7; sb_if.issue_use_rs2 = 1'b1;
        #1;
        push("raw7_stall", 64'h0);          check(64'(sb_if.issue_ready));
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 7;
        #1;
        push("raw7_wb_bypass", 64'h1);      check(64'(sb_if.issue_ready));
        step();
        idle_inputs();
        push("wb7_vec", 64'h0);             check(64'(sb_if.pending_vec));
        push("wb7_count", 64'h0);           check(64'(sb_if.pending_count));

        // WAW on r3, then same-cycle set/clear
        long_issue(3);
        step();
        #1;
        push("waw3_stall", 64'h0);          check(64'(sb_if.issue_ready));
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 3;
        #1;
        push("waw3_wb_ready", 64'h1);       check(64'(sb_if.issue_ready));
        step();
        push("setwins_vec", 64'h8);         check(64'(sb_if.pending_vec));
        push("setwins_count", 64'h1);       check(64'(sb_if.pending_count));
        idle_inputs();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 3;
        step();
        idle_inputs();
        push("clr3_count", 64'h0);          check(64'(sb_if.pending_count));
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 3;
        step();
        idle_inputs();
        push("wb_nonpending_count", 64'h0); check(64'(sb_if.pending_count));

        // Register 0 is never tracked and never stalls
        long_issue(0);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 0;
        #1;
        push("r0_ready", 64'h1);            check(64'(sb_if.issue_ready));
        step();
        push("r0_vec", 64'h0);              check(64'(sb_if.pending_vec));
        idle_inputs();
        sb_if.issue_valid = 1'b1; sb_if.issue_use_rs1 = 1'b1; sb_if.issue_rs1 = 0;
        #1;
        push("r0_src_ready", 64'h1);        check(64'(sb_if.issue_ready));

        // Flush beats simultaneous writeback and long issue
        long_issue(1); step();
        long_issue(2); step();
        long_issue(4); step();
        idle_inputs();
        push("pend3_vec", 64'h16);          check(64'(sb_if.pending_vec));
        push("pend3_count", 64'h3);         check(64'(sb_if.pending_count));
        long_issue(9);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 2; sb_if.flush = 1'b1;
        #1;
        push("flush_ready", 64'h0);         check(64'(sb_if.issue_ready));
        step();
        idle_inputs();
        push("flush_vec", 64'h0);           check(64'(sb_if.pending_vec));
        push("flush_count", 64'h0);         check(64'(sb_if.pending_count));

        // Watchdog: r6 never returns
        long_issue(6);
        step();
        idle_inputs();
        push("wd_vec6", 64'h40);            check(64'(sb_if.pending_vec));
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            push($sformatf("wd_quiet_%0d", i), 64'h0);
            check(64'(sb_if.timeout_err));
        end
        step();
        push("wd_fire", 64'h1);             check(64'(sb_if.timeout_err));
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 6;
        step();
        idle_inputs();
        push("wd_sticky_wb", 64'h1);        check(64'(sb_if.timeout_err));
        push("wd_wb_count", 64'h0);         check(64'(sb_if.pending_count));
        sb_if.flush = 1'b1;
        step();
        idle_inputs();
        push("wd_sticky_flush", 64'h1);     check(64'(sb_if.timeout_err));
        rst_n = 1'b0;
        #1;
        push("wd_reset_clear", 64'h0);      check(64'(sb_if.timeout_err));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
